// File: rtl/ariane_regfile_lvt.sv
// ariane_regfile_lvt: multi-port register file for FPGA builds, built from
// dual-port block RAM banks plus a live-value table (LVT) that tracks which
// write port holds the newest copy of each word. A clear sequencer zeroes the
// RAM after reset, since block RAM contents cannot be reset.
// Optional feature macro: ARIANE_REGFILE_BYPASS_EN (write-first forwarding of
// same-cycle writes to reads); without it reads are read-first.

// Dual-port block RAM bank: port A writes, port B reads (read-first).
module bram_tdp_rf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned AW         = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  en_a_i,
    input  logic                  we_a_i,
    input  logic [AW-1:0]         addr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  en_b_i,
    input  logic [AW-1:0]         addr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o
);
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // Port A write
    always_ff @(posedge clk_i) begin
        if (en_a_i && we_a_i) mem_q[addr_a_i] <= wdata_a_i;
    end

    // Port B registered read; returns the pre-write word on a same-edge write
    always_ff @(posedge clk_i) begin
        if (en_b_i) rdata_b_o <= mem_q[addr_b_i];
    end
endmodule

module ariane_regfile_lvt #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_WORDS      = 32,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ZERO_REG_ZERO  = 0
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_ni,
    input  logic                                                     test_en_i,
    input  logic [NR_READ_PORTS-1:0][$clog2(NUM_WORDS)-1:0]          raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]                 rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][$clog2(NUM_WORDS)-1:0]         waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]                wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                                we_i,
    output logic                                                     init_done_o
);
    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam int unsigned LW = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;

    typedef enum logic {CLEAR, READY} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clearing;

    logic [NR_WRITE_PORTS-1:0]                 we_masked;
    logic [NR_WRITE_PORTS-1:0]                 bank_we;
    logic [NR_WRITE_PORTS-1:0][AW-1:0]         bank_waddr;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0]                     bank_rdata [NR_WRITE_PORTS][NR_READ_PORTS];

    logic [LW-1:0]                             lvt_q [NUM_WORDS];

    logic [NR_READ_PORTS-1:0][AW-1:0]          raddr_p1;
    logic [NR_READ_PORTS-1:0][LW-1:0]          lvt_sel_p1;
    logic                                      vld_p1;

    // Clock gating is not used inside; the bypass input is kept for port compatibility
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // Clear sequencer state and address counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Walk every address once, then stay READY until the next reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(NUM_WORDS - 1)) state_d = READY;
        end
    end

    // Sequencer outputs
    always_comb begin
        clearing    = (state_q == CLEAR);
        init_done_o = (state_q == READY);
    end

    // Write-port steering: user writes in READY, zero-fill through port 0 while clearing
    always_comb begin
        for (int w = 0; w < NR_WRITE_PORTS; w++) begin
            we_masked[w]  = we_i[w] && !clearing &&
                            !((ZERO_REG_ZERO != 0) && (waddr_i[w] == '0));
            bank_we[w]    = we_masked[w];
            bank_waddr[w] = waddr_i[w];
            bank_wdata[w] = wdata_i[w];
        end
        if (clearing) begin
            bank_we[0]    = 1'b1;
            bank_waddr[0] = clr_cnt_q;
            bank_wdata[0] = '0;
        end
    end

    // One bank per (write port, read port) pair
    for (genvar w = 0; w < NR_WRITE_PORTS; w++) begin : g_wr
        for (genvar r = 0; r < NR_READ_PORTS; r++) begin : g_rd
            bram_tdp_rf #(
                .DATA_WIDTH (DATA_WIDTH),
                .NUM_WORDS  (NUM_WORDS),
                .AW         (AW)
            ) i_bank (
                .clk_i     (clk_i),
                .en_a_i    (1'b1),
                .we_a_i    (bank_we[w]),
                .addr_a_i  (bank_waddr[w]),
                .wdata_a_i (bank_wdata[w]),
                .en_b_i    (1'b1),
                .addr_b_i  (raddr_i[r]),
                .rdata_b_o (bank_rdata[w][r])
            );
        end
    end

    // Live-value table; ascending loop lets the highest-indexed colliding port win
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WORDS; i++) lvt_q[i] <= '0;
        end else if (clearing) begin
            lvt_q[clr_cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NR_WRITE_PORTS; w++) begin
                if (we_masked[w]) lvt_q[waddr_i[w]] <= LW'(w);
            end
        end
    end

    // ---- stage p0 -> p1: capture read address, LVT selector and readiness ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raddr_p1   <= '0;
            lvt_sel_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            raddr_p1 <= raddr_i;
            for (int r = 0; r < NR_READ_PORTS; r++) lvt_sel_p1[r] <= lvt_q[raddr_i[r]];
            vld_p1   <= (state_q == READY);
        end
    end

`ifdef ARIANE_REGFILE_BYPASS_EN
    logic [NR_READ_PORTS-1:0]                 hit_p0, hit_p1;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] fwd_p0, fwd_p1;

    // Detect a same-cycle write to the address being read; last matching port wins
    always_comb begin
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            hit_p0[r] = 1'b0;
            fwd_p0[r] = '0;
            for (int w = 0; w < NR_WRITE_PORTS; w++) begin
                if (we_masked[w] && (waddr_i[w] == raddr_i[r])) begin
                    hit_p0[r] = 1'b1;
                    fwd_p0[r] = wdata_i[w];
                end
            end
        end
    end

    // ---- stage p0 -> p1: capture forwarding hit and word ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_p1 <= '0;
            fwd_p1 <= '0;
        end else begin
            hit_p1 <= hit_p0;
            fwd_p1 <= fwd_p0;
        end
    end
`endif

    // Read mux: newest bank per LVT, optional forwarding, zero during clear and for x0
    always_comb begin
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            rdata_o[r] = '0;
            if (vld_p1) begin
                rdata_o[r] = bank_rdata[lvt_sel_p1[r]][r];
`ifdef ARIANE_REGFILE_BYPASS_EN
                if (hit_p1[r]) rdata_o[r] = fwd_p1[r];
`endif
                if ((ZERO_REG_ZERO != 0) && (raddr_p1[r] == '0)) rdata_o[r] = '0;
            end
        end
    end
endmodule

// File: tb/tb_ariane_regfile_lvt.sv
// Bench for ariane_regfile_lvt: 32 words, 2 read / 2 write ports, zero register on.
module tb_ariane_regfile_lvt;
    localparam int DW  = 32;
    localparam int NW  = 32;
    localparam int NRP = 2;
    localparam int NWP = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_ni;
    logic                         test_en;
    logic [NRP-1:0][AW-1:0]       raddr;
    logic [NRP-1:0][DW-1:0]       rdata;
    logic [NWP-1:0][AW-1:0]       waddr;
    logic [NWP-1:0][DW-1:0]       wdata;
    logic [NWP-1:0]               we;
    logic                         init_done;

    int checks = 0;
    int errors = 0;

    ariane_regfile_lvt #(
        .DATA_WIDTH     (DW),
        .NUM_WORDS      (NW),
        .NR_READ_PORTS  (NRP),
        .NR_WRITE_PORTS (NWP),
        .ZERO_REG_ZERO  (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .test_en_i   (test_en),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .we_i        (we),
        .init_done_o (init_done)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic          chk;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    typedef struct {
        logic          chk;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        string         name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we0, input int wa0, input logic [DW-1:0] wd0,
                                 input logic we1, input int wa1, input logic [DW-1:0] wd1,
                                 input int ra0, input int ra1, input logic chk,
                                 input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        vec_t v;
        v.we0 = we0; v.wa0 = AW'(wa0); v.wd0 = wd0;
        v.we1 = we1; v.wa1 = AW'(wa1); v.wd1 = wd1;
        v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
        v.chk = chk; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic drain_one();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check({e.name, "_r0"}, rdata[0], e.e0);
                check({e.name, "_r1"}, rdata[1], e.e1);
            end
        end
    endtask

    task automatic step(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        drain_one();
        we[0] = v.we0; waddr[0] = v.wa0; wdata[0] = v.wd0;
        we[1] = v.we1; waddr[1] = v.wa1; wdata[1] = v.wd1;
        raddr[0] = v.ra0; raddr[1] = v.ra1;
        e.chk = v.chk; e.e0 = v.e0; e.e1 = v.e1; e.name = name;
        sb.push_back(e);
    endtask

    task automatic flush();
        @(negedge clk);
        drain_one();
        we = '0;
        raddr = '0;
    endtask

    // Counts the clear window from the first edge after release
    task automatic run_clear(input string name);
        for (int k = 1; k <= NW; k++) begin
            @(negedge clk);
            check({name, "_done"}, DW'(init_done), DW'(k == NW));
            check({name, "_rd0"}, rdata[0], '0);
        end
    endtask

    initial begin
        logic [DW-1:0] same_cycle_exp;
`ifdef ARIANE_REGFILE_BYPASS_EN
        same_cycle_exp = 32'h9;
`else
        same_cycle_exp = 32'h5;
`endif
        vecs.push_back(mkv(1, 5, 32'hA5A5_0001, 1, 9, 32'h1234_5678, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 5, 9, 1, 32'hA5A5_0001, 32'h1234_5678));
        vecs.push_back(mkv(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 3, 32'h22, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 3, 3, 1, 32'h22, 32'h22));
        vecs.push_back(mkv(1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 7, 7, 1, 32'hBB, 32'hBB));
        vecs.push_back(mkv(1, 4, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 4, 32'h9, 4, 9, 1, same_cycle_exp, 32'h1234_5678));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 4, 4, 1, 32'h9, 32'h9));
        vecs.push_back(mkv(1, 0, 32'hFF, 1, 10, 32'hCAFE, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 10, 1, 32'h0, 32'hCAFE));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 32'hFF, 0, 5, 1, 32'h0, 32'hA5A5_0001));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 9, 32'h77, 1, 31, 32'h3131_3131, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 9, 31, 1, 32'h77, 32'h3131_3131));
        vecs.push_back(mkv(1, 2, 32'h2222, 1, 6, 32'h6666, 3, 7, 1, 32'h22, 32'hBB));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 2, 6, 1, 32'h2222, 32'h6666));

        // Reset state
        rst_ni  = 1'b0;
        test_en = 1'b0;
        raddr   = '0;
        waddr   = '0;
        wdata   = '0;
        we      = '0;
        repeat (2) @(negedge clk);
        check("reset_rd0", rdata[0], '0);
        check("reset_rd1", rdata[1], '0);
        check("reset_done", DW'(init_done), '0);

        // First clear, with writes presented that must be ignored
        raddr[0] = 5; raddr[1] = 6;
        we = 2'b11;
        waddr[0] = 6; wdata[0] = 32'hDEAD;
        waddr[1] = 5; wdata[1] = 32'hBEEF;
        rst_ni = 1'b1;
        run_clear("clr1");
        we = '0;

        // Every word reads back zero after the clear
        for (int a = 0; a < NW; a++) begin
            step(mkv(0, 0, 0, 0, 0, 0, a, NW - 1 - a, 1, 0, 0), $sformatf("clr_rd_%0d", a));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end
        flush();

        // Reset during operation, then again ten cycles into the clear
        raddr[0] = 31; raddr[1] = 5;
        rst_ni = 1'b0;
        @(negedge clk);
        check("rst2_rd0", rdata[0], '0);
        check("rst2_done", DW'(init_done), '0);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        check("midclr_done", DW'(init_done), '0);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        run_clear("clr2");

        step(mkv(0, 0, 0, 0, 0, 0, 31, 5, 1, 0, 0), "post_rd_a");
        step(mkv(0, 0, 0, 0, 0, 0, 3, 7, 1, 0, 0), "post_rd_b");
        step(mkv(0, 0, 0, 0, 0, 0, 9, 4, 1, 0, 0), "post_rd_c");
        step(mkv(1, 0, 32'hFF, 0, 0, 0, 0, 10, 1, 0, 0), "post_rd_d");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "post_rd_e");
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
